// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the ysyx_25020047 instruction fetch unit.
package ysyx_25020047_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding word read, registered result handed to decode.
// Optional macro IFU_ALIGN_CHECK_EN turns a misaligned fetch PC into a local fault.
module ysyx_25020047_ifu
  import ysyx_25020047_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_fault,
  output ifu_state_t        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // raised, valid and its payload hold until that edge (or a redirect squashes it).
  ifu_state_t        r_state;
  ifu_state_t        w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       w_fetch_pc_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_nxt;
  logic [31:0]       r_inst_pc;
  logic [31:0]       w_inst_pc_nxt;
  logic              r_inst_fault;
  logic              w_inst_fault_nxt;
  logic              w_misaligned;
  logic              w_req_fire;

`ifdef IFU_ALIGN_CHECK_EN
  assign w_misaligned = |r_fetch_pc[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign mem_req_valid = (r_state == REQ) && !w_misaligned;
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign inst_valid    = (r_state == HOLD);
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_fault    = r_inst_fault;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_drop_nxt       = r_drop;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_fault_nxt = r_inst_fault;
    unique case (r_state)
      IDLE: begin
        if (redirect_valid) w_fetch_pc_nxt = redirect_pc;
        w_state_nxt = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          if (w_req_fire) begin
            w_state_nxt = WAIT;
            w_drop_nxt  = 1'b1;
          end
        end else if (w_misaligned) begin
          w_state_nxt      = HOLD;
          w_inst_nxt       = NOP_INST;
          w_inst_pc_nxt    = r_fetch_pc;
          w_inst_fault_nxt = 1'b1;
        end else if (w_req_fire) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          if (mem_rsp_valid) begin
            w_state_nxt = REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          // A squashed request still owes us its response; swallow it here.
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = REQ;
          end else begin
            w_inst_nxt       = mem_rsp_err ? NOP_INST : mem_rsp_data;
            w_inst_pc_nxt    = r_fetch_pc;
            w_inst_fault_nxt = mem_rsp_err;
            w_fetch_pc_nxt   = r_fetch_pc + 32'd4;
            w_state_nxt      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = REQ;
        end else if (inst_ready) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_fault <= w_inst_fault_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: memory responder, decode-side scoreboard, scenario tasks.
module tb_ysyx_25020047_ifu;
  import ysyx_25020047_pkg::*;

  localparam int W = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  ifu_state_t  dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  int          rsp_lat = 1;
  bit          rand_lat = 1'b0;
  int          expect_drop = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  int          n_req = 0;
  int          n_xfer = 0;

  ysyx_25020047_ifu dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .o_dbg_state(dbg_state)
  );

  // Clock / reset: reset is released inside test_reset.
  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0010_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) smp();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== RESET_PC) begin n_err++; $display("FAIL rst_req_addr got=%h exp=%h", mem_req_addr, RESET_PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got=%h exp=0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    n_cmp++; if (inst_fault !== 1'b0) begin n_err++; $display("FAIL rst_inst_fault got=%b exp=0", inst_fault); end
    cyc(); rst = 1'b0; mem_req_ready = 1'b1; inst_ready = 1'b1; rsp_lat = 1; smp();
    n_cmp++; if (mem_req_valid !== 1'b0 || dbg_state !== IDLE) begin n_err++; $display("FAIL idle_c0 got valid=%b state=%0d exp valid=0 state=IDLE", mem_req_valid, dbg_state); end
  endtask

  task automatic test_first_fetch();
    cyc(); smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin n_err++; $display("FAIL first_req got valid=%b addr=%h exp 1/%h", mem_req_valid, mem_req_addr, RESET_PC); end
    cyc(); smp();
    n_cmp++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL first_wait got req=%b iv=%b exp 0/0", mem_req_valid, inst_valid); end
    cyc(); smp();
    n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== RESET_PC || inst_fault !== 1'b0) begin
      n_err++; $display("FAIL first_inst got v=%b i=%h pc=%h f=%b exp 1/00100093/%h/0", inst_valid, inst, inst_pc, inst_fault, RESET_PC);
    end
    cyc(); mem_req_ready = 1'b0; smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004) begin n_err++; $display("FAIL second_req got valid=%b addr=%h exp 1/80000004", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_hold_stall();
    int req0;
    cyc(); inst_ready = 1'b0; mem_req_ready = 1'b1; smp();
    cyc(); mem_req_ready = 1'b0; smp();
    req0 = n_req;
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      n_cmp++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h8000_0004) || inst_pc !== 32'h8000_0004 || mem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL hold_stable[%0d] got v=%b i=%h pc=%h req=%b", i, inst_valid, inst, inst_pc, mem_req_valid);
      end
    end
    n_cmp++; if (n_req !== req0) begin n_err++; $display("FAIL hold_no_req got=%0d exp=%0d", n_req, req0); end
    cyc(); inst_ready = 1'b1; smp();
    cyc(); smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0008) begin n_err++; $display("FAIL after_hold_req got valid=%b addr=%h exp 1/80000008", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_fault();
    err_en = 1'b1; err_addr = 32'h8000_0008;
    cyc(); mem_req_ready = 1'b1; smp();
    cyc(); mem_req_ready = 1'b0; smp();
    cyc(); smp();
    n_cmp++; if (inst_valid !== 1'b1 || inst !== NOP_INST || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0008) begin
      n_err++; $display("FAIL fault_inst got v=%b i=%h f=%b pc=%h exp 1/00000013/1/80000008", inst_valid, inst, inst_fault, inst_pc);
    end
    cyc(); smp();
    err_en = 1'b0;
    n_cmp++; if (mem_req_addr !== 32'h8000_000C) begin n_err++; $display("FAIL fault_next_addr got=%h exp=8000000c", mem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    cyc(); mem_req_ready = 1'b1; rsp_lat = 3; smp();
    cyc(); mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; expect_drop = 1; smp();
    n_cmp++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL rdw_wait got req=%b iv=%b exp 0/0", mem_req_valid, inst_valid); end
    cyc(); redirect_valid = 1'b0; smp();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdw_still_wait got req=%b exp 0", mem_req_valid); end
    cyc(); smp();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rdw_rsp_cycle got iv=%b exp 0", inst_valid); end
    cyc(); rsp_lat = 1; smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rdw_new_req got req=%b addr=%h iv=%b exp 1/80000100/0", mem_req_valid, mem_req_addr, inst_valid);
    end
  endtask

  task automatic test_wrap();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; smp();
    cyc(); redirect_valid = 1'b0; mem_req_ready = 1'b1; smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req got valid=%b addr=%h exp 1/fffffffc", mem_req_valid, mem_req_addr); end
    cyc(); mem_req_ready = 1'b0; smp();
    cyc(); smp();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
      n_err++; $display("FAIL wrap_inst got v=%b pc=%h i=%h", inst_valid, inst_pc, inst);
    end
    cyc(); smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got valid=%b addr=%h exp 1/00000000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_back_to_back();
    int x0, r0;
    x0 = n_xfer; r0 = n_req;
    for (int i = 0; i < 12; i++) begin
      cyc(); mem_req_ready = 1'b1; smp();
    end
    cyc(); mem_req_ready = 1'b0; smp();
    n_cmp++; if (n_xfer - x0 !== 4) begin n_err++; $display("FAIL b2b_xfers got=%0d exp=4", n_xfer - x0); end
    n_cmp++; if (n_req - r0 !== 4) begin n_err++; $display("FAIL b2b_reqs got=%0d exp=4", n_req - r0); end
    n_cmp++; if (mem_req_addr !== 32'h0000_0010) begin n_err++; $display("FAIL b2b_addr got=%h exp=00000010", mem_req_addr); end
  endtask

  task automatic test_align();
    int r0;
    r0 = n_req;
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; inst_ready = 1'b0; smp();
    cyc(); redirect_valid = 1'b0; smp();
`ifdef IFU_ALIGN_CHECK_EN
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL align_suppress got req=%b exp 0", mem_req_valid); end
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; smp();
    n_cmp++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0102 || inst !== NOP_INST) begin
      n_err++; $display("FAIL align_fault got v=%b f=%b pc=%h i=%h exp 1/1/80000102/00000013", inst_valid, inst_fault, inst_pc, inst);
    end
`else
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0102) begin n_err++; $display("FAIL misalign_issue got req=%b addr=%h exp 1/80000102", mem_req_valid, mem_req_addr); end
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; smp();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL misalign_no_inst got iv=%b exp 0", inst_valid); end
`endif
    cyc(); redirect_valid = 1'b0; inst_ready = 1'b1; smp();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL align_recover got req=%b addr=%h iv=%b exp 1/80000200/0", mem_req_valid, mem_req_addr, inst_valid);
    end
    n_cmp++; if (n_req !== r0) begin n_err++; $display("FAIL align_req_count got=%0d exp=%0d", n_req, r0); end
  endtask

  task automatic test_random();
    int x0, r0;
    x0 = n_xfer; r0 = n_req; rand_lat = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cyc(); mem_req_ready = 1'($urandom_range(0, 1)); inst_ready = ($urandom_range(0, 3) != 0); smp();
    end
    cyc(); mem_req_ready = 1'b0; inst_ready = 1'b1; smp();
    repeat (8) begin cyc(); smp(); end
    rand_lat = 1'b0;
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rand_drain got=%0d pending exp=0", exp_q.size()); end
    n_cmp++; if (n_xfer - x0 !== n_req - r0) begin n_err++; $display("FAIL rand_balance got xfers=%0d exp=%0d", n_xfer - x0, n_req - r0); end
  endtask

  initial begin
    fork
      // Memory responder: one response rsp_lat cycles after each accepted request.
      forever begin
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_err = err_en && (pend_addr == err_addr);
            mem_rsp_data = mem_word(pend_addr);
            if (expect_drop > 0) expect_drop--;
            else exp_q.push_back({pend_addr, mem_rsp_err ? NOP_INST : mem_rsp_data, mem_rsp_err});
          end
        end
        @(negedge clk);
        if (!rst && mem_req_valid && mem_req_ready) begin
          pend = 1'b1; pend_addr = mem_req_addr; n_req++;
          cnt = rand_lat ? int'($urandom_range(1, 3)) : rsp_lat;
        end
      end
      // Decode-side scoreboard.
      forever begin
        @(negedge clk);
        if (!rst && inst_valid && inst_ready) begin
          n_xfer++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_unexpected got pc=%h inst=%h exp none", inst_pc, inst);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({inst_pc, inst, inst_fault} !== e) begin
              n_err++; $display("FAIL sb_xfer got pc=%h i=%h f=%b exp pc=%h i=%h f=%b", inst_pc, inst, inst_fault, e[64:33], e[32:1], e[0]);
            end
          end
        end
      end
      begin
        repeat (20000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_fault();
    test_redirect_wait();
    test_wrap();
    test_back_to_back();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_ifu.md
# ysyx_25020047_ifu

Instruction fetch unit: the producer side of the decode unit's instruction interface. Holds the fetch PC, issues one word read per instruction to the instruction memory port, registers the returned word, and presents it with its PC to the decode stage over a valid/ready handshake. A redirect input loads a new fetch PC (jump/branch target from write-back) and squashes any in-flight or buffered instruction.

## Interface
- RESET_PC, 32'h8000_0000, fetch PC loaded on reset
- NOP_INST, 32'h0000_0013, instruction word driven on a fault
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  load redirect_pc as next fetch PC, flush pipeline state
- redirect_pc  in  32  redirect target
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word address (byte address, 4-aligned when legal)
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read data
- mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid
- inst_valid  out  1  inst/inst_pc valid toward decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- inst_fault  out  1  fetch fault for this instruction

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset -> IDLE; IDLE -> REQ unconditionally next cycle.
- REQ: mem_req_valid=1, mem_req_addr=fetch_pc. On mem_req_valid&&mem_req_ready -> WAIT.
- WAIT: mem_req_valid=0. On mem_rsp_valid: capture inst<=mem_rsp_data, inst_pc<=fetch_pc, inst_fault<=mem_rsp_err, fetch_pc<=fetch_pc+4 (mod 2^32, wraps), -> HOLD. On fault, inst<=NOP_INST.
- HOLD: inst_valid=1, outputs stable. On inst_ready -> REQ.
- One outstanding request maximum; mem_rsp_valid outside WAIT is ignored.
- Redirect (highest priority, any state except IDLE): fetch_pc<=redirect_pc.
  - REQ without handshake: stay REQ, address updates next cycle.
  - REQ with handshake same cycle: -> WAIT with drop=1.
  - WAIT without rsp: set drop=1, stay WAIT. Response arriving while drop=1 is discarded, drop cleared, -> REQ.
  - WAIT with rsp same cycle: response discarded, -> REQ, drop stays 0.
  - HOLD: inst_valid deasserted next cycle, -> REQ. A same-cycle inst_ready still counts as a completed transfer.
- Redirect in IDLE is applied to fetch_pc; IDLE -> REQ unchanged.

## Timing
- Reset values: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, drop=0, fetch_pc=RESET_PC.
- First request visible cycle 1 after reset release.
- Request handshake cycle N -> earliest mem_rsp_valid N+1 -> inst_valid N+2.
- Peak throughput with zero-wait memory and inst_ready held high: one instruction per 3 cycles.
- All outputs registered or decoded from state/registers only; no combinational path from any input to any output.
- Reset mid-transaction abandons everything; memory must tolerate a dropped response.

## Configuration
- IFU_ALIGN_CHECK_EN defined: in REQ, fetch_pc[1:0]!=0 suppresses mem_req_valid; next cycle -> HOLD with inst=NOP_INST, inst_pc=fetch_pc, inst_fault=1; fetch_pc unchanged (recovery only via redirect).
- Not defined: misaligned fetch_pc issued as-is; inst_fault driven only by mem_rsp_err.

## Structure
- Shared package ysyx_25020047_pkg: FSM state enum, RESET_PC and NOP_INST constants, instruction width.
- Single module; no sub-module needed, FSM plus output register fit one file.

## Test plan
- Reset release, memory returns 32'h0010_0093 one cycle after accept, inst_ready=1 -> inst_valid at cycle 3, inst_pc=32'h8000_0000, next mem_req_addr=32'h8000_0004.
- inst_ready low 5 cycles in HOLD -> inst/inst_pc stable, mem_req_valid stays 0, no second request.
- Redirect to 32'h8000_0100 in WAIT, response 2 cycles later -> response dropped, next mem_req_addr=32'h8000_0100, no inst_valid for dropped word.
- mem_rsp_err=1 at 32'h8000_0008 -> inst=32'h0000_0013, inst_fault=1, inst_pc=32'h8000_0008.
- IFU_ALIGN_CHECK_EN, redirect to 32'h8000_0102 -> no memory request, inst_fault=1, inst_pc=32'h8000_0102.
- fetch_pc=32'hFFFF_FFFC fetched -> next mem_req_addr=32'h0000_0000.
